data_data_rd_streamer: RTL and testbench



---
 rtl/data_data_pkg.sv | 44 ++++
 rtl/data_data_rd_streamer_if.sv | 41 ++++
 rtl/data_data_beat_buf.sv | 54 +++++
 rtl/data_data_rd_streamer.sv | 124 ++++++++++++
 tb/tb_data_data_rd_streamer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_data_pkg.sv
// ---------------------------------------------------------------------------
// data_data_pkg
// Shared types and constants for the L1 data-array read streamer.
//   DEPTH/AW/DW/MAXB : array geometry and command limits
//   rd_state_t       : streamer FSM state
//   beat_t           : one buffered output beat (data, last, optional parity)
//   calc_par()       : per-32-bit-lane even parity of a row
//   next_row()       : row increment with wrap at DEPTH-1
// Optional feature macro: DATA_RD_STREAMER_PARITY_EN (adds beat_t.par).
// ---------------------------------------------------------------------------
package data_data_pkg;

    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int DW    = 128;
    localparam int MAXB  = 4;

    // Sized copies so comparisons against port fields stay width-matched.
    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
    localparam logic [2:0]    MAXB_C   = 3'(MAXB);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
`ifdef DATA_RD_STREAMER_PARITY_EN
        logic [3:0]    par;
`endif
    } beat_t;

    function automatic logic [3:0] calc_par(input logic [DW-1:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[32*i +: 32];
        end
        return p;
    endfunction

    function automatic logic [AW-1:0] next_row(input logic [AW-1:0] r);
        return (r == LAST_ROW) ? '0 : r + 1'b1;
    endfunction

endpackage

// File: rtl/data_data_rd_streamer_if.sv
// ---------------------------------------------------------------------------
// data_data_rd_streamer_if
// Command and beat-stream handshake bundle for data_data_rd_streamer.
//   req_valid/req_ready/req_row/req_beats/req_err : line-read command
//   beat_valid/beat_ready/beat_data/beat_last     : output beat stream
//   beat_par (DATA_RD_STREAMER_PARITY_EN only)    : per-lane beat parity
// slave modport = streamer side, master modport = command issuer / sink.
// ---------------------------------------------------------------------------
interface data_data_rd_streamer_if;
    import data_data_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_row;
    logic [2:0]    req_beats;
    logic          req_err;
    logic          beat_valid;
    logic          beat_ready;
    logic [DW-1:0] beat_data;
    logic          beat_last;
`ifdef DATA_RD_STREAMER_PARITY_EN
    logic [3:0]    beat_par;
`endif

    modport slave (
        input  req_valid, req_row, req_beats, beat_ready,
`ifdef DATA_RD_STREAMER_PARITY_EN
        output beat_par,
`endif
        output req_ready, req_err, beat_valid, beat_data, beat_last
    );

    modport master (
        output req_valid, req_row, req_beats, beat_ready,
`ifdef DATA_RD_STREAMER_PARITY_EN
        input  beat_par,
`endif
        input  req_ready, req_err, beat_valid, beat_data, beat_last
    );

endinterface

// File: rtl/data_data_beat_buf.sv
// ---------------------------------------------------------------------------
// data_data_beat_buf
// Two-entry FIFO of beat_t between the array read port and the beat stream.
//   clock, reset : clock / synchronous active-high reset (control only)
//   push         : write push_beat at the clock edge
//   push_beat    : beat to store
//   pop          : drop the head entry at the clock edge
//   count        : occupancy 0..2
//   head         : oldest entry (meaningful only when count != 0)
// Caller guarantees no push when full unless it also pops, and no pop when
// empty. Push and pop together while full writes the slot being vacated.
// ---------------------------------------------------------------------------
module data_data_beat_buf
    import data_data_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output logic [1:0] count,
    output beat_t      head
);

    beat_t      mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by cnt alone.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_beat;
    end

    assign count = cnt;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/data_data_rd_streamer.sv
// ---------------------------------------------------------------------------
// data_data_rd_streamer
// Read-side initiator for the 40x128 L1 data array. Accepts a line-read
// command (start row, beat count), reads consecutive rows through the
// macro R0 port (wrapping DEPTH-1 -> 0) and streams each row as a beat.
// Ports:
//   clock, reset : sole clock, synchronous active-high reset
//   bus (slave)  : command handshake + beat stream (see interface)
//   R0_addr/R0_en/R0_clk : macro read port (R0_clk = clock)
//   R0_data      : macro read data, valid in the same cycle as R0_en
//   busy         : FSM not in IDLE
// Optional feature macro: DATA_RD_STREAMER_PARITY_EN adds bus.beat_par.
// ---------------------------------------------------------------------------
module data_data_rd_streamer
    import data_data_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    data_data_rd_streamer_if.slave  bus,
    output logic [AW-1:0]           R0_addr,
    output logic                    R0_en,
    output logic                    R0_clk,
    input  logic [DW-1:0]           R0_data,
    output logic                    busy
);

    rd_state_t     state, state_nxt;
    logic [AW-1:0] cur_row;
    logic [2:0]    remaining;
    logic [AW-1:0] last_addr;
    logic          err_q;

    logic          cmd_fire;
    logic          cmd_legal;
    logic          issue;
    logic          pop;
    logic          beat_valid;
    logic [1:0]    count;
    beat_t         push_beat;
    beat_t         head;

    assign R0_clk    = clock;
    assign cmd_fire  = (state == IDLE) && bus.req_valid;
    assign cmd_legal = (bus.req_row <= LAST_ROW) && (bus.req_beats != 3'd0)
                       && (bus.req_beats <= MAXB_C);
    assign beat_valid = (count != 2'd0);
    assign pop        = beat_valid && bus.beat_ready;
    // A full buffer can still take a row when the head leaves this cycle.
    assign issue      = (state == READ) && ((count != 2'd2) || pop);

    always_comb begin
        state_nxt = state;
        R0_en     = 1'b0;
        R0_addr   = last_addr;
        case (state)
            IDLE: begin
                if (cmd_fire && cmd_legal) state_nxt = READ;
            end
            READ: begin
                if (issue) begin
                    R0_en   = 1'b1;
                    R0_addr = cur_row;
                    if (remaining == 3'd1) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (count == 2'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur_row   <= '0;
            remaining <= 3'd0;
            last_addr <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= cmd_fire && !cmd_legal;
            if (cmd_fire && cmd_legal) begin
                cur_row   <= bus.req_row;
                remaining <= bus.req_beats;
            end else if (issue) begin
                cur_row   <= next_row(cur_row);
                remaining <= remaining - 3'd1;
                last_addr <= cur_row;
            end
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = R0_data;
        push_beat.last = (remaining == 3'd1);
`ifdef DATA_RD_STREAMER_PARITY_EN
        push_beat.par  = calc_par(R0_data);
`endif
    end

    data_data_beat_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (issue),
        .push_beat (push_beat),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // Payload is forced to zero while empty so unreset storage never leaks.
    assign bus.req_ready  = (state == IDLE);
    assign bus.req_err    = err_q;
    assign bus.beat_valid = beat_valid;
    assign bus.beat_data  = beat_valid ? head.data : '0;
    assign bus.beat_last  = beat_valid ? head.last : 1'b0;
`ifdef DATA_RD_STREAMER_PARITY_EN
    assign bus.beat_par   = beat_valid ? head.par : 4'd0;
`endif
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_data_rd_streamer.sv
module tb_data_data_rd_streamer;
    import data_data_pkg::*;

    logic          clock;
    logic          reset;
    logic [AW-1:0] R0_addr;
    logic          R0_en;
    logic          R0_clk;
    logic [DW-1:0] R0_data;
    logic          busy;

    data_data_rd_streamer_if bus();

    data_data_rd_streamer dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .R0_addr (R0_addr),
        .R0_en   (R0_en),
        .R0_clk  (R0_clk),
        .R0_data (R0_data),
        .busy    (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Array model: 64 entries so out-of-range addresses still read something.
    logic [DW-1:0] mem [64];
    assign R0_data = mem[R0_addr];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [3:0]    par;
    } exp_t;

    exp_t          exp_q [$];
    logic [AW-1:0] addr_q [$];

    int vectors;
    int miscompares;
    int r0_count;
    logic err_pending;
    logic hold_v;
    logic [DW-1:0] hold_data;
    logic hold_last;
    logic rand_mode;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: actual=timeout/empty required=event at %0t", nm, $time);
    endtask

    function automatic logic [3:0] lane_par(input logic [DW-1:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[32*i +: 32];
        return p;
    endfunction

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        int   row;
        int   nb;
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            err_pending = 1'b0;
            hold_v      = 1'b0;
        end else begin
            chk("req_err", 128'(bus.req_err), 128'(err_pending));
            err_pending = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                row = int'(bus.req_row);
                nb  = int'(bus.req_beats);
                if (row < DEPTH && nb >= 1 && nb <= MAXB) begin
                    for (int i = 0; i < nb; i++) begin
                        e.data = mem[(row + i) % DEPTH];
                        e.last = (i == nb - 1);
                        e.par  = lane_par(e.data);
                        exp_q.push_back(e);
                        addr_q.push_back(AW'((row + i) % DEPTH));
                    end
                end else begin
                    err_pending = 1'b1;
                end
            end
            if (R0_en) begin
                r0_count++;
                chk("r0_in_range", 128'(R0_addr < AW'(DEPTH)), 128'(1));
                if (addr_q.size() == 0) fail_now("r0_unexpected_read");
                else chk("r0_addr", 128'(R0_addr), 128'(addr_q.pop_front()));
            end
            if (hold_v && bus.beat_valid) begin
                chk("stable_data", bus.beat_data, hold_data);
                chk("stable_last", 128'(bus.beat_last), 128'(hold_last));
            end
            hold_v    = bus.beat_valid && !bus.beat_ready;
            hold_data = bus.beat_data;
            hold_last = bus.beat_last;
            if (bus.beat_valid && bus.beat_ready) begin
                if (exp_q.size() == 0) fail_now("beat_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.beat_data, e.data);
                    chk("beat_last", 128'(bus.beat_last), 128'(e.last));
`ifdef DATA_RD_STREAMER_PARITY_EN
                    chk("beat_par", 128'(bus.beat_par), 128'(e.par));
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_mode) bus.beat_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [AW-1:0] row, input logic [2:0] beats);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) fail_now("req_ready_wait");
        bus.req_valid = 1'b1;
        bus.req_row   = row;
        bus.req_beats = beats;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || bus.beat_valid) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) fail_now("wait_idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_beat_valid"}, 128'(bus.beat_valid), 128'(0));
        chk({tag, "_beat_last"},  128'(bus.beat_last), 128'(0));
        chk({tag, "_beat_data"},  bus.beat_data, 128'(0));
        chk({tag, "_R0_en"},      128'(R0_en), 128'(0));
        chk({tag, "_R0_addr"},    128'(R0_addr), 128'(0));
        chk({tag, "_req_err"},    128'(bus.req_err), 128'(0));
        chk({tag, "_busy"},       128'(busy), 128'(0));
        chk({tag, "_req_ready"},  128'(bus.req_ready), 128'(1));
`ifdef DATA_RD_STREAMER_PARITY_EN
        chk({tag, "_beat_par"},   128'(bus.beat_par), 128'(0));
`endif
    endtask

    initial begin
        int c0;
        vectors       = 0;
        miscompares   = 0;
        r0_count      = 0;
        err_pending   = 1'b0;
        hold_v        = 1'b0;
        hold_data     = '0;
        hold_last     = 1'b0;
        rand_mode     = 1'b0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        bus.req_beats = 3'd0;
        bus.beat_ready = 1'b1;
        for (int i = 0; i < 64; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_outputs("post_reset");
        chk("clk_out", 128'(R0_clk), 128'(clock));

        // Basic stream with latency and throughput checks.
        send(6'd5, 3'd4);
        chk("lat_c0_r0en", 128'(R0_en), 128'(1));
        chk("lat_c0_bvalid", 128'(bus.beat_valid), 128'(0));
        chk("busy_active", 128'(busy), 128'(1));
        for (int i = 1; i < 4; i++) begin
            step();
            chk("tput_r0en", 128'(R0_en), 128'(1));
            chk("tput_bvalid", 128'(bus.beat_valid), 128'(1));
        end
        step();
        chk("tail_r0en", 128'(R0_en), 128'(0));
        chk("tail_bvalid", 128'(bus.beat_valid), 128'(1));
        chk("tail_last", 128'(bus.beat_last), 128'(1));
        wait_idle();
        chk("idle_r0addr_hold", 128'(R0_addr), 128'(8));

        // Wrap-around.
        send(6'd38, 3'd4);
        wait_idle();

        // Backpressure: only two reads fit while the sink stalls.
        bus.beat_ready = 1'b0;
        send(6'd10, 3'd4);
        c0 = r0_count;
        repeat (5) step();
        chk("bp_reads", 128'(r0_count - c0), 128'(2));
        chk("bp_r0en_off", 128'(R0_en), 128'(0));
        bus.beat_ready = 1'b1;
        wait_idle();
        chk("bp_drained", 128'(exp_q.size()), 128'(0));

        // Illegal commands.
        c0 = r0_count;
        send(6'd40, 3'd2);
        chk("ill_row_ready", 128'(bus.req_ready), 128'(1));
        step();
        send(6'd3, 3'd0);
        chk("ill_b0_ready", 128'(bus.req_ready), 128'(1));
        step();
        send(6'd3, 3'd5);
        chk("ill_b5_ready", 128'(bus.req_ready), 128'(1));
        step();
        step();
        chk("ill_no_reads", 128'(r0_count - c0), 128'(0));
        chk("ill_idle", 128'(busy), 128'(0));

        // Reset mid-operation.
        send(6'd20, 3'd4);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("mid_reset");
        send(6'd2, 3'd3);
        wait_idle();

`ifdef DATA_RD_STREAMER_PARITY_EN
        mem[3] = 128'h1;
        send(6'd3, 3'd1);
        step();
        chk("par_lane0", 128'(bus.beat_par), 128'(4'b0001));
        wait_idle();
`endif

        // Randomized commands with random backpressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send(AW'($urandom_range(0, 45)), 3'($urandom_range(0, 5)));
            repeat ($urandom_range(0, 3)) step();
        end
        rand_mode = 1'b0;
        bus.beat_ready = 1'b1;
        wait_idle();
        step();
        chk("final_beats_left", 128'(exp_q.size()), 128'(0));
        chk("final_reads_left", 128'(addr_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
